// File: rtl/req_encoder.sv
// Captures a multi-hot request vector and emits one binary index per accepted code,
// in priority order. Codes appear 1 cycle after capture. A stalled code_ready holds the current code.
module req_encoder #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       req_valid,
  output logic       req_ready,
  output logic [2:0] code,
  output logic       code_valid,
  input  logic       code_ready,
  output logic [3:0] pending,
  output logic       done,
  output logic       empty
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t     state;
  logic [7:0] pend_q;
  logic [7:0] pend_cleared;

  function automatic logic [2:0] prio(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [3:0] popcnt(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  // Outputs are registered, so the next code is looked up from the post-handshake vector.
  assign pend_cleared = pend_q & ~(8'd1 << code);
  assign req_ready    = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pend_q     <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      pending    <= '0;
      done       <= 1'b0;
      empty      <= 1'b0;
    end else begin
      done  <= 1'b0;
      empty <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            pend_q  <= req;
            pending <= popcnt(req);
            if (req != 8'd0) begin
              state      <= EMIT;
              code       <= prio(req);
              code_valid <= 1'b1;
            end else begin
              empty <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (code_ready) begin
            pend_q  <= pend_cleared;
            pending <= popcnt(pend_cleared);
            if (pend_cleared != 8'd0) begin
              code <= prio(pend_cleared);
            end else begin
              state      <= IDLE;
              code       <= '0;
              code_valid <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/req_encoder.md
REQ_ENCODER -- requirements
Module: req_encoder

Interface
- REQ-001 Parameter LSB_FIRST, default 1: 1 = bit 0 highest priority; 0 = bit 7 highest priority.
- REQ-002 clk  input  1  single clock; all state changes on rising edge.
- REQ-003 rst  input  1  reset, asynchronous, active-high.
- REQ-004 req  input  8  request vector; multi-hot allowed; bit n maps to code n (3'b000 -> bit 0 ... 3'b111 -> bit 7).
- REQ-005 req_valid  input  1  req is valid this cycle.
- REQ-006 req_ready  output  1  block idle, accepts a new vector.
- REQ-007 code  output  3  binary index of the current highest-priority pending bit.
- REQ-008 code_valid  output  1  code is valid.
- REQ-009 code_ready  input  1  consumer accepts code this cycle.
- REQ-010 pending  output  4  count of bits not yet emitted, 0..8.
- REQ-011 done  output  1  one-cycle pulse after the last code of a vector is accepted.
- REQ-012 empty  output  1  one-cycle pulse when an all-zero vector is accepted.

Function
- REQ-013 Two states SHALL exist: IDLE and EMIT; req_ready SHALL be 1 exactly when the state is IDLE.
- REQ-014 Capture: in IDLE with req_valid=1, the rising edge SHALL load req into an internal 8-bit pending register and set pending to popcount(req).
- REQ-015 A non-zero capture SHALL go to EMIT; code_valid SHALL be 1 in the next cycle (1-cycle latency from capture).
- REQ-016 An all-zero capture SHALL stay in IDLE, pulse empty for one cycle, keep code_valid=0, and leave req_ready at 1.
- REQ-017 In EMIT, code SHALL be the index of the highest-priority set bit of the pending register per LSB_FIRST.
- REQ-018 code and code_valid SHALL stay stable while code_valid=1 and code_ready=0.
- REQ-019 Handshake: on code_valid=1 and code_ready=1, the edge SHALL clear that bit and decrement pending by 1.
- REQ-020 If bits remain after a handshake, the next code SHALL be valid in the following cycle with no bubble; code_ready held at 1 SHALL drain one code per cycle.
- REQ-021 If no bits remain after a handshake, the state SHALL return to IDLE, code_valid SHALL drop, done SHALL pulse for exactly one cycle, and req_ready SHALL be 1 in that same cycle.
- REQ-022 req and req_valid SHALL be ignored outside IDLE; the pending register SHALL change only on a handshake.
- REQ-023 pending SHALL equal the popcount of the internal pending register at all times.
- REQ-024 done and empty SHALL never be asserted in the same cycle.
- REQ-025 Outputs code, code_valid, done, empty and pending SHALL be registered.

Reset
- REQ-026 Asserting rst SHALL immediately force the following, with no clock needed: state IDLE, pending register 0, code 3'b000, code_valid 0, pending 0, done 0, empty 0, req_ready 1.
- REQ-027 Asserting rst mid-EMIT SHALL discard all undelivered bits; after rst deasserts, no stale code SHALL appear.
- REQ-028 With rst held, req_valid SHALL NOT cause a capture.

Verification
- REQ-029 LSB_FIRST=1, req=8'b1010_0100 captured, code_ready=1 -> codes 2, 5, 7 on three consecutive cycles; pending 3,2,1; done pulses in the cycle after code 7 is accepted.
- REQ-030 LSB_FIRST=0, same vector -> codes 7, 5, 2 in that order.
- REQ-031 req=8'hFF, code_ready toggling 1,0,1,0 -> each code held stable while code_ready=0; all 8 codes 0..7 delivered exactly once; pending ends at 0.
- REQ-032 req=8'h00 with req_valid=1 -> empty pulses for one cycle, code_valid stays 0, req_ready stays 1.
- REQ-033 Capture 8'h0F, accept code 0, assert rst asynchronously between clock edges -> outputs reach reset values before the next edge; after release, code_valid=0 and req_ready=1.
- REQ-034 New req_valid with req=8'h80 while in EMIT -> ignored; codes of the original vector are unaffected.
